cache_arbiter: RTL and testbench

Arbitrates the single burst-memory port (to L2/physical memory) between the I-cache miss path and the D-cache miss/writeback path. Sits between `Icache`/`Dcache1` memory-side ports and the top-level `mem_*` burst interface of `mp4`. Serves one 256-bit line transaction at a time and latches the winning requester's address and data for the whole transaction. Forwards the response only to the owner.

---
 rtl/cache_arb_types.sv | 19 +
 rtl/cache_arbiter_grant.sv | 31 +++
 rtl/cache_arbiter.sv | 89 ++++++++
 tb/tb_cache_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_types.sv
// Shared types for the cache_arbiter slice: FSM states, transaction owner, default widths.
// Optional policy macro used by this slice: CACHE_ARB_ROUND_ROBIN_EN.
package cache_arb_types;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RECOVER
    } arb_state_t;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } arb_owner_t;

endpackage

// File: rtl/cache_arbiter_grant.sv
// Combinational owner pick between I-cache and D-cache line requests.
// CACHE_ARB_ROUND_ROBIN_EN: contention goes to the side not served last; otherwise D-cache always wins.
module cache_arbiter_grant
    import cache_arb_types::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_owner,
    output logic       grant,
    output arb_owner_t owner
);

    logic contend_pick_i;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    assign contend_pick_i = (last_owner == OWNER_D);
`else
    logic unused_last_owner;
    assign contend_pick_i    = 1'b0;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant = i_req | d_req;
        owner = OWNER_D;
        if (i_req && (!d_req || contend_pick_i)) begin
            owner = OWNER_I;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Single-port burst-memory arbiter between I-cache misses and D-cache misses/writebacks.
// CACHE_ARB_ROUND_ROBIN_EN selects round-robin instead of D-first fixed priority (see cache_arbiter_grant).
module cache_arbiter #(
    parameter int LINE_W = cache_arb_types::LINE_W,
    parameter int ADDR_W = cache_arb_types::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    import cache_arb_types::*;

    arb_state_t        state, state_nxt;
    arb_owner_t        owner_q, last_owner_q, grant_owner;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              grant, take, busy, pick_d;

    cache_arbiter_grant u_grant (
        .i_req      (i_read),
        .d_req      (d_read | d_write),
        .last_owner (last_owner_q),
        .grant      (grant),
        .owner      (grant_owner)
    );

    assign take   = (state == IDLE) && grant;
    assign pick_d = (grant_owner == OWNER_D);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    if (mem_resp) state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset pointer says I-cache was served last, so the first contention goes to D-cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner_q      <= OWNER_I;
            last_owner_q <= OWNER_I;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner_q      <= grant_owner;
                last_owner_q <= grant_owner;
                write_q      <= pick_d && d_write;
                addr_q       <= pick_d ? d_address : i_address;
                wdata_q      <= pick_d ? d_wdata : '0;
            end
        end
    end

    assign busy        = (state == BUSY);
    assign mem_read    = busy && !write_q;
    assign mem_write   = busy && write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

    // A requester that abandoned its request mid-transaction gets no completion.
    assign i_resp  = busy && mem_resp && (owner_q == OWNER_I) && i_read;
    assign d_resp  = busy && mem_resp && (owner_q == OWNER_D) && (d_read || d_write);
    assign i_rdata = busy ? mem_rdata : '0;
    assign d_rdata = busy ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expected downstream requests and
// cache responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    typedef struct {
        logic              is_d;
        logic [LINE_W-1:0] data;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read, d_read, d_write, mem_resp;
    logic [ADDR_W-1:0] i_address, d_address;
    logic [LINE_W-1:0] d_wdata, mem_rdata;
    logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
    logic              i_resp, d_resp, mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    req_t held;
    rsp_t r;
    logic prev_act = 1'b0;
    logic [LINE_W-1:0] wd;
    int vectors = 0;
    int miscompares = 0;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [LINE_W-1:0] act,
                                input logic [LINE_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: downstream request on its first BUSY cycle, then hold; cache responses.
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            if (!prev_act) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_mem_req", mem_read | mem_write, 0);
                    held = '{mem_write, mem_address, mem_wdata};
                end else begin
                    held = exp_req.pop_front();
                    chk("mem_write_op", mem_write, held.write);
                    chk("mem_read_op", mem_read, !held.write);
                    chk("mem_address", mem_address, held.addr);
                    chk("mem_wdata", mem_wdata, held.wdata);
                end
            end else begin
                chk("hold_op", mem_write, held.write);
                chk("hold_address", mem_address, held.addr);
                chk("hold_wdata", mem_wdata, held.wdata);
            end
        end
        prev_act = mem_read | mem_write;
        if (i_resp || d_resp) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_resp", {i_resp, d_resp}, 0);
            end else begin
                r = exp_rsp.pop_front();
                chk("resp_owner", {i_resp, d_resp}, r.is_d ? 2'b01 : 2'b10);
                chk("resp_rdata", r.is_d ? d_rdata : i_rdata, r.data);
            end
        end
    end

    // Memory model: wait for the downstream request, delay, then one-cycle completion.
    task automatic serve(input logic [LINE_W-1:0] data, input int delay);
        int n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("mem_req_timeout", mem_read | mem_write, 1);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        mem_resp  = 1'b1;
        mem_rdata = data;
        @(posedge clk); #1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    // Simultaneous I read and D request; i_first says which side must be served first.
    task automatic pair(input logic i_first, input logic d_wr, input logic [ADDR_W-1:0] ia,
                        input logic [ADDR_W-1:0] da, input logic [LINE_W-1:0] dw,
                        input logic [LINE_W-1:0] idat, input logic [LINE_W-1:0] ddat);
        req_t ri = '{1'b0, ia, {LINE_W{1'b0}}};
        req_t rd = '{d_wr, da, dw};
        if (i_first) begin
            exp_req.push_back(ri); exp_req.push_back(rd);
            exp_rsp.push_back('{1'b0, idat}); exp_rsp.push_back('{1'b1, ddat});
        end else begin
            exp_req.push_back(rd); exp_req.push_back(ri);
            exp_rsp.push_back('{1'b1, ddat}); exp_rsp.push_back('{1'b0, idat});
        end
        i_read = 1'b1; i_address = ia;
        d_read = 1'b1; d_write = d_wr; d_address = da; d_wdata = dw;
        serve(i_first ? idat : ddat, 1);
        if (i_first) i_read = 1'b0;
        else begin d_read = 1'b0; d_write = 1'b0; end
        serve(i_first ? ddat : idat, 0);
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        // Stray completion while IDLE must not reach either cache.
        mem_resp = 1'b1; mem_rdata = {64{4'hF}};
        #1;
        chk("idle_resp_i", i_resp, 0);
        chk("idle_resp_d", d_resp, 0);
        chk("idle_rdata_i", i_rdata, 0);
        @(posedge clk); #1;
        mem_resp = 1'b0; mem_rdata = '0;

        // I-cache only, then back-to-back I miss after RECOVER + IDLE.
        exp_req.push_back('{1'b0, 32'h60, {LINE_W{1'b0}}});
        exp_rsp.push_back('{1'b0, {32{8'hA5}}});
        i_read = 1'b1; i_address = 32'h60;
        @(posedge clk); #1;
        chk("i_only_mem_read", mem_read, 1);
        chk("i_only_mem_address", mem_address, 32'h60);
        serve({32{8'hA5}}, 2);
        i_read = 1'b0;
        chk("recover_no_req", mem_read | mem_write, 0);
        @(posedge clk); #1;
        chk("b2b_idle_no_req", mem_read | mem_write, 0);
        exp_req.push_back('{1'b0, 32'h80, {LINE_W{1'b0}}});
        exp_rsp.push_back('{1'b0, {32{8'h5A}}});
        i_read = 1'b1; i_address = 32'h80;
        @(posedge clk); #1;
        chk("b2b_mem_read_rise", mem_read, 1);
        serve({32{8'h5A}}, 0);
        i_read = 1'b0;
        @(posedge clk); #1;

        // D writeback; I-cache requests and changes address while D owns the port.
        wd = {16{16'h1234}};
        exp_req.push_back('{1'b1, 32'h1000, wd});
        exp_rsp.push_back('{1'b1, {8{32'hDEADBEEF}}});
        d_write = 1'b1; d_address = 32'h1000; d_wdata = wd;
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 32'h60;
        @(posedge clk); #1;
        i_address = 32'h80;
        #1;
        chk("nonowner_addr_hold", mem_address, 32'h1000);
        chk("wb_mem_write", mem_write, 1);
        exp_req.push_back('{1'b0, 32'h80, {LINE_W{1'b0}}});
        exp_rsp.push_back('{1'b0, {8{32'hCAFEF00D}}});
        serve({8{32'hDEADBEEF}}, 1);
        d_write = 1'b0; d_address = '0; d_wdata = '0;
        serve({8{32'hCAFEF00D}}, 0);
        i_read = 1'b0;
        @(posedge clk); #1;

        // Contention after an I grant: D first under either policy.
        pair(1'b0, 1'b0, 32'h140, 32'h240, '0, {32{8'h11}}, {32{8'h22}});
        // Lone D read so the last grant is D.
        exp_req.push_back('{1'b0, 32'h2000, {LINE_W{1'b0}}});
        exp_rsp.push_back('{1'b1, {32{8'h33}}});
        d_read = 1'b1; d_address = 32'h2000;
        serve({32{8'h33}}, 0);
        d_read = 1'b0;
        @(posedge clk); #1;
        // Contention after a D grant, with d_read+d_write (write wins the op).
        pair(RR, 1'b1, 32'h180, 32'h280, {8{32'h0BADF00D}}, {32{8'h44}}, {32{8'h55}});

        // Requester abandons its read mid-transaction: completion is swallowed.
        exp_req.push_back('{1'b0, 32'h400, {LINE_W{1'b0}}});
        i_read = 1'b1; i_address = 32'h400;
        @(posedge clk); #1;
        i_read = 1'b0;
        serve({32{8'h66}}, 0);
        @(posedge clk); #1;

        // Reset while BUSY: request drops next edge, late completion ignored.
        exp_req.push_back('{1'b0, 32'h300, {LINE_W{1'b0}}});
        i_read = 1'b1; i_address = 32'h300;
        @(posedge clk); #1;
        chk("pre_reset_busy", mem_read, 1);
        rst = 1'b1; i_read = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_busy_read", mem_read, 0);
        chk("reset_in_busy_write", mem_write, 0);
        rst = 1'b0;
        mem_resp = 1'b1; mem_rdata = {32{8'h77}};
        #1;
        chk("late_resp_i", i_resp, 0);
        chk("late_resp_d", d_resp, 0);
        @(posedge clk); #1;
        mem_resp = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("after_reset_idle", mem_read | mem_write, 0);
        chk("req_queue_drained", exp_req.size(), 0);
        chk("rsp_queue_drained", exp_rsp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
